// File: rtl/paddle_encoder_if.sv
// Encoder contacts in, paddle bitmask and position out.
`timescale 1ns/1ps
interface paddle_encoder_if;
    logic        enc_a;
    logic        enc_b;
    logic [31:0] paddle;
    logic [4:0]  position;

    modport master (output enc_a, output enc_b, input paddle, input position);
    modport slave  (input enc_a, input enc_b, output paddle, output position);
endinterface

// File: rtl/paddle_encoder.sv
// Quadrature encoder to clamped paddle bitmask: sync, debounce, decode, accumulate.
`timescale 1ns/1ps
module paddle_encoder #(
    parameter int WIDTH    = 5,
    parameter int INIT_POS = 13,
    parameter int DEBOUNCE = 3,
    parameter int QSTEPS   = 4
) (
    input  logic            clk,
    input  logic            reset,
    paddle_encoder_if.slave bus
);
    localparam logic [4:0]        MAX_POS = 5'(32 - WIDTH);
    localparam logic [4:0]        RST_POS = 5'(INIT_POS);
    localparam logic [31:0]       BASE    = 32'((64'd1 << WIDTH) - 64'd1);
    localparam logic [3:0]        DB      = 4'(DEBOUNCE);
    localparam logic signed [3:0] Q_POS   = 4'(QSTEPS);
    localparam logic signed [3:0] Q_NEG   = 4'(-QSTEPS);

    logic [1:0] w_raw;
    logic [1:0] r_sync1, r_sync2;
    logic [1:0] w_filt;
    logic [1:0] r_prev;

    assign w_raw = {bus.enc_a, bus.enc_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Bit 1 is channel A, bit 0 is channel B.
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic       r_f;
        logic [3:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_f   <= 1'b0;
                r_cnt <= '0;
            end else if (r_sync2[i] == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt + 4'd1 == DB) begin
                r_f   <= r_sync2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end

        assign w_filt[i] = r_f;
    end

    logic signed [1:0] w_delta;
    logic signed [3:0] w_sum;
    logic [2:0]        r_acc;
    logic [2:0]        w_acc_nxt;
    logic [4:0]        r_pos;
    logic [4:0]        w_pos_nxt;
    logic [31:0]       r_paddle;

    // Forward Gray order 00 -> 01 -> 11 -> 10 -> 00; double-bit flips count as no motion.
    always_comb begin
        w_delta = 2'sb00;
        case ({r_prev, w_filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_delta = 2'sb01;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: w_delta = 2'sb11;
            default:                                w_delta = 2'sb00;
        endcase
    end

    assign w_sum = {r_acc[2], r_acc} + {{2{w_delta[1]}}, w_delta};

    // A completed detent always clears the accumulator, even when the position is pinned.
    always_comb begin
        w_acc_nxt = w_sum[2:0];
        w_pos_nxt = r_pos;
        if (w_sum == Q_POS) begin
            w_acc_nxt = '0;
            if (r_pos != MAX_POS) w_pos_nxt = r_pos + 5'd1;
        end else if (w_sum == Q_NEG) begin
            w_acc_nxt = '0;
            if (r_pos != 5'd0) w_pos_nxt = r_pos - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev   <= '0;
            r_acc    <= '0;
            r_pos    <= RST_POS;
            r_paddle <= BASE << RST_POS;
        end else begin
            r_prev   <= w_filt;
            r_acc    <= w_acc_nxt;
            r_pos    <= w_pos_nxt;
            r_paddle <= BASE << w_pos_nxt;
        end
    end

    assign bus.paddle   = r_paddle;
    assign bus.position = r_pos;
endmodule
